// File: rtl/spi_master_multi.sv
// SPI master with configurable word width, SCK divider and slave-select count.
// Supports per-transfer CPOL/CPHA and HOLD to keep a slave selected across bursts.
module spi_master_multi #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SS     = 4,
    parameter int unsigned SEL_WIDTH  = 2,
    parameter int unsigned CLK_DIV    = 24
) (
    input  logic                  CLK_48MHZ,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic [SEL_WIDTH-1:0]  SS_SEL,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  HOLD,
    input  logic                  MISO,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic [NUM_SS-1:0]     SS,
    output logic                  MOSI,
    output logic                  SPI_SCK
);

    localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HALF_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int unsigned SELX_W = SEL_WIDTH + 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD_WAIT,
        S_TEARDOWN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [NUM_SS-1:0]     ss_q, ss_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  mosi_q, mosi_d;
    logic                  sck_q, sck_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  sel_ok_c;
    logic                  load_c;
    logic                  toggle_c;

    assign sel_ok_c = SELX_W'(SS_SEL) < SELX_W'(NUM_SS);

    // State and datapath registers
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            ss_q    <= '1;
            sel_q   <= '0;
            mosi_q  <= 1'b0;
            sck_q   <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            ss_q    <= ss_d;
            sel_q   <= sel_d;
            mosi_q  <= mosi_d;
            sck_q   <= sck_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; START in SETUP/XFER is deliberately ignored
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        tx_sh_d  = tx_sh_q;
        rx_sh_d  = rx_sh_q;
        rx_d     = rx_q;
        ss_d     = ss_q;
        sel_d    = sel_q;
        mosi_d   = mosi_q;
        sck_d    = sck_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load_c   = 1'b0;
        toggle_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                sck_d = cpol_q;
                if (START) begin
                    if (sel_ok_c) begin
                        sel_d   = SS_SEL;
                        cpol_d  = CPOL;
                        cpha_d  = CPHA;
                        sck_d   = CPOL;
                        ss_d    = ~(NUM_SS'(1) << SS_SEL);
                        cnt_d   = CNT_RELOAD;
                        load_c  = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    toggle_c = 1'b1;
                    state_d  = S_XFER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_XFER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (half_q == HALF_LAST) begin
                    rx_d   = rx_sh_q;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    if (HOLD) begin
                        state_d = S_HOLD_WAIT;
                    end else begin
                        ss_d    = '1;
                        cnt_d   = CNT_RELOAD;
                        state_d = S_TEARDOWN;
                    end
                end else begin
                    toggle_c = 1'b1;
                end
            end
            S_HOLD_WAIT: begin
                // A burst word skips the long setup: the slave is already selected
                if (START) begin
                    if (SS_SEL == sel_q) begin
                        cnt_d   = '0;
                        load_c  = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (!HOLD) begin
                    ss_d    = '1;
                    cnt_d   = CNT_RELOAD;
                    state_d = S_TEARDOWN;
                end
            end
            S_TEARDOWN: begin
                err_d = START;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_c) begin
            busy_d = 1'b1;
            half_d = '0;
            if (cpha_d) begin
                tx_sh_d = TX_DATA;
            end else begin
                mosi_d  = TX_DATA[DATA_WIDTH-1];
                tx_sh_d = TX_DATA << 1;
            end
        end

        // Toggle n = half_q+1; sample on odd toggles for CPHA=0, even for CPHA=1
        if (toggle_c) begin
            sck_d  = ~sck_q;
            half_d = half_q + HALF_W'(1);
            cnt_d  = CNT_RELOAD;
            if (half_q[0] == cpha_q) begin
                rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], MISO};
            end else begin
                mosi_d  = tx_sh_q[DATA_WIDTH-1];
                tx_sh_d = tx_sh_q << 1;
            end
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign RX_DATA = rx_q;
    assign SS      = ss_q;
    assign MOSI    = mosi_q;
    assign SPI_SCK = sck_q;

endmodule
